// File: rtl/as2650_bus_pkg.sv
// rtl/as2650_bus_pkg.sv - shared types and constants for the AS2650 external bus sequencer
package as2650_bus_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ADDR_HI,
    ADDR_LO,
    READ,
    WRITE,
    WHOLD
  } bus_state_t;

  localparam logic PORT_CPU = 1'b0;
  localparam logic PORT_AUX = 1'b1;

  localparam int MAX_WAIT_STATES = 3;

endpackage

// File: rtl/as2650_bus_rr_arb.sv
// rtl/as2650_bus_rr_arb.sv - two-port round-robin arbiter with last-grant register and ack mask
module as2650_bus_rr_arb
  import as2650_bus_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req_i,
  input  logic [1:0] mask_i,
  input  logic       take_i,
  output logic       gnt_valid_o,
  output logic       gnt_port_o
);

  logic       last_q;
  logic       last_d;
  logic [1:0] elig;

  // A port being acked this cycle still shows its old request, so it is masked out.
  always_comb begin
    elig        = req_i & ~mask_i;
    gnt_valid_o = |elig;
    case (elig)
      2'b01:   gnt_port_o = PORT_CPU;
      2'b10:   gnt_port_o = PORT_AUX;
      2'b11:   gnt_port_o = ~last_q;
      default: gnt_port_o = PORT_CPU;
    endcase
    last_d = (take_i && gnt_valid_o) ? gnt_port_o : last_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) last_q <= PORT_AUX;
    else     last_q <= last_d;
  end

endmodule

// File: rtl/as2650_bus_sequencer.sv
// rtl/as2650_bus_sequencer.sv - multiplexed 8-bit bus sequencer (addr-hi/addr-lo latch, read, write) for two requesters
module as2650_bus_sequencer
  import as2650_bus_pkg::*;
#(
  parameter int WAIT_STATES = 0,
  parameter bit SKIP_HI     = 1'b1
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  input  logic [1:0]  req_i,
  input  logic [1:0]  we_i,
  input  logic [15:0] addr0_i,
  input  logic [15:0] addr1_i,
  input  logic [7:0]  wdata0_i,
  input  logic [7:0]  wdata1_i,
  output logic [1:0]  ack_o,
  output logic [7:0]  rdata_o,
  input  logic [7:0]  bus_in,
  output logic [7:0]  bus_out,
  output logic        bus_oe,
  output logic        le_hi,
  output logic        le_lo,
  output logic        OEb,
  output logic        WEb
);

  localparam int         WS_CLAMP = (WAIT_STATES > MAX_WAIT_STATES) ? MAX_WAIT_STATES : WAIT_STATES;
  localparam logic [1:0] WS_L     = WS_CLAMP[1:0];

  bus_state_t  state_q, state_d;
  logic [15:0] addr_q, addr_d;
  logic        we_q, we_d;
  logic [7:0]  wdata_q, wdata_d;
  logic        port_q, port_d;
  logic [1:0]  wait_q, wait_d;
  logic        hi_valid_q, hi_valid_d;
  logic [7:0]  hi_byte_q, hi_byte_d;
  logic [7:0]  bus_out_q, bus_out_d;
  logic        bus_oe_q, bus_oe_d;
  logic        oeb_q, oeb_d;
  logic        web_q, web_d;
  logic [1:0]  ack_q, ack_d;
  logic [7:0]  rdata_q, rdata_d;
  logic        st_hi_q, st_hi_d;
  logic        st_lo_q, st_lo_d;
  logic        neg_hi_q, neg_lo_q;

  logic        gnt_valid;
  logic        gnt_port;
  logic [15:0] sel_addr;

  as2650_bus_rr_arb u_arb (
    .clk         (wb_clk_i),
    .rst         (wb_rst_i),
    .req_i       (req_i),
    .mask_i      (ack_q),
    .take_i      (state_q == IDLE),
    .gnt_valid_o (gnt_valid),
    .gnt_port_o  (gnt_port)
  );

  assign sel_addr = gnt_port ? addr1_i : addr0_i;

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    we_d       = we_q;
    wdata_d    = wdata_q;
    port_d     = port_q;
    wait_d     = wait_q;
    hi_valid_d = hi_valid_q;
    hi_byte_d  = hi_byte_q;
    bus_out_d  = bus_out_q;
    bus_oe_d   = bus_oe_q;
    oeb_d      = oeb_q;
    web_d      = web_q;
    ack_d      = 2'b00;
    rdata_d    = rdata_q;
    st_hi_d    = 1'b0;
    st_lo_d    = 1'b0;
    case (state_q)
      IDLE: begin
        bus_oe_d = 1'b1;
        oeb_d    = 1'b1;
        web_d    = 1'b1;
        if (gnt_valid) begin
          port_d  = gnt_port;
          addr_d  = sel_addr;
          we_d    = we_i[gnt_port];
          wdata_d = gnt_port ? wdata1_i : wdata0_i;
          wait_d  = 2'd0;
          if (!SKIP_HI || !hi_valid_q || (sel_addr[15:8] != hi_byte_q)) begin
            state_d    = ADDR_HI;
            bus_out_d  = sel_addr[15:8];
            st_hi_d    = 1'b1;
            hi_valid_d = 1'b1;
            hi_byte_d  = sel_addr[15:8];
          end else begin
            state_d   = ADDR_LO;
            bus_out_d = sel_addr[7:0];
            st_lo_d   = 1'b1;
          end
        end
      end
      ADDR_HI: begin
        state_d   = ADDR_LO;
        bus_out_d = addr_q[7:0];
        st_lo_d   = 1'b1;
      end
      ADDR_LO: begin
        wait_d = 2'd0;
        if (we_q) begin
          state_d   = WRITE;
          bus_out_d = wdata_q;
          bus_oe_d  = 1'b1;
          web_d     = 1'b0;
        end else begin
          state_d  = READ;
          bus_oe_d = 1'b0;
          oeb_d    = 1'b0;
        end
      end
      READ: begin
        if (wait_q == WS_L) begin
          state_d        = IDLE;
          oeb_d          = 1'b1;
          bus_oe_d       = 1'b1;
          rdata_d        = bus_in;
          ack_d[port_q]  = 1'b1;
        end else begin
          wait_d = wait_q + 2'd1;
        end
      end
      WRITE: begin
        if (wait_q == WS_L) begin
          state_d = WHOLD;
          web_d   = 1'b1;
        end else begin
          wait_d = wait_q + 2'd1;
        end
      end
      WHOLD: begin
        state_d       = IDLE;
        ack_d[port_q] = 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state_q    <= IDLE;
      addr_q     <= 16'h0000;
      we_q       <= 1'b0;
      wdata_q    <= 8'h00;
      port_q     <= PORT_CPU;
      wait_q     <= 2'd0;
      hi_valid_q <= 1'b0;
      hi_byte_q  <= 8'h00;
      bus_out_q  <= 8'h00;
      bus_oe_q   <= 1'b1;
      oeb_q      <= 1'b1;
      web_q      <= 1'b1;
      ack_q      <= 2'b00;
      rdata_q    <= 8'h00;
      st_hi_q    <= 1'b0;
      st_lo_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      we_q       <= we_d;
      wdata_q    <= wdata_d;
      port_q     <= port_d;
      wait_q     <= wait_d;
      hi_valid_q <= hi_valid_d;
      hi_byte_q  <= hi_byte_d;
      bus_out_q  <= bus_out_d;
      bus_oe_q   <= bus_oe_d;
      oeb_q      <= oeb_d;
      web_q      <= web_d;
      ack_q      <= ack_d;
      rdata_q    <= rdata_d;
      st_hi_q    <= st_hi_d;
      st_lo_q    <= st_lo_d;
    end
  end

  // Latch enables are high only for the first half of their cycle so the latches close mid-cycle.
  always_ff @(negedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      neg_hi_q <= 1'b0;
      neg_lo_q <= 1'b0;
    end else begin
      neg_hi_q <= st_hi_q;
      neg_lo_q <= st_lo_q;
    end
  end

  assign le_hi   = st_hi_q & ~neg_hi_q;
  assign le_lo   = st_lo_q & ~neg_lo_q;
  assign bus_out = bus_out_q;
  assign bus_oe  = bus_oe_q;
  assign OEb     = oeb_q;
  assign WEb     = web_q;
  assign ack_o   = ack_q;
  assign rdata_o = rdata_q;

endmodule

// File: tb/tb_as2650_bus_sequencer.sv
// tb/tb_as2650_bus_sequencer.sv - directed self-checking bench for as2650_bus_sequencer
module tb_as2650_bus_sequencer;

  logic        clk;
  logic        rst;

  logic [1:0]  a_req, a_we, a_ack;
  logic [15:0] a_addr0, a_addr1;
  logic [7:0]  a_wdata0, a_wdata1, a_rdata, a_bus_in, a_bus_out;
  logic        a_bus_oe, a_le_hi, a_le_lo, a_oeb, a_web;

  logic [1:0]  b_req, b_we, b_ack;
  logic [15:0] b_addr0, b_addr1;
  logic [7:0]  b_wdata0, b_wdata1, b_rdata, b_bus_in, b_bus_out;
  logic        b_bus_oe, b_le_hi, b_le_lo, b_oeb, b_web;

  int checks;
  int fails;

  as2650_bus_sequencer #(.WAIT_STATES(0), .SKIP_HI(1'b1)) u_dut (
    .wb_clk_i (clk),      .wb_rst_i (rst),
    .req_i    (a_req),    .we_i     (a_we),
    .addr0_i  (a_addr0),  .addr1_i  (a_addr1),
    .wdata0_i (a_wdata0), .wdata1_i (a_wdata1),
    .ack_o    (a_ack),    .rdata_o  (a_rdata),
    .bus_in   (a_bus_in), .bus_out  (a_bus_out), .bus_oe (a_bus_oe),
    .le_hi    (a_le_hi),  .le_lo    (a_le_lo),
    .OEb      (a_oeb),    .WEb      (a_web)
  );

  as2650_bus_sequencer #(.WAIT_STATES(2), .SKIP_HI(1'b1)) u_ws2 (
    .wb_clk_i (clk),      .wb_rst_i (rst),
    .req_i    (b_req),    .we_i     (b_we),
    .addr0_i  (b_addr0),  .addr1_i  (b_addr1),
    .wdata0_i (b_wdata0), .wdata1_i (b_wdata1),
    .ack_o    (b_ack),    .rdata_o  (b_rdata),
    .bus_in   (b_bus_in), .bus_out  (b_bus_out), .bus_oe (b_bus_oe),
    .le_hi    (b_le_hi),  .le_lo    (b_le_lo),
    .OEb      (b_oeb),    .WEb      (b_web)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    a_req = 2'b00; a_we = 2'b00; a_addr0 = 16'h0; a_addr1 = 16'h0;
    a_wdata0 = 8'h0; a_wdata1 = 8'h0; a_bus_in = 8'h0;
    b_req = 2'b00; b_we = 2'b00; b_addr0 = 16'h0; b_addr1 = 16'h0;
    b_wdata0 = 8'h0; b_wdata1 = 8'h0; b_bus_in = 8'h0;
    tick; tick;
    checks++; if (a_bus_out !== 8'h00) begin fails++; $display("FAIL rst_bus_out: got %h want 00", a_bus_out); end
    checks++; if (a_bus_oe !== 1'b1) begin fails++; $display("FAIL rst_bus_oe: got %b want 1", a_bus_oe); end
    checks++; if ({a_le_hi, a_le_lo} !== 2'b00) begin fails++; $display("FAIL rst_le: got %b want 00", {a_le_hi, a_le_lo}); end
    checks++; if ({a_oeb, a_web} !== 2'b11) begin fails++; $display("FAIL rst_strobes: got %b want 11", {a_oeb, a_web}); end
    checks++; if (a_ack !== 2'b00) begin fails++; $display("FAIL rst_ack: got %b want 00", a_ack); end
    checks++; if (a_rdata !== 8'h00) begin fails++; $display("FAIL rst_rdata: got %h want 00", a_rdata); end
  endtask

  task automatic test_reset_release_read;
    a_req = 2'b01; a_we = 2'b00; a_addr0 = 16'h0000; a_bus_in = 8'h04;
    rst = 1'b0;
    tick;
    checks++; if (a_le_hi !== 1'b1 || a_bus_out !== 8'h00) begin fails++; $display("FAIL rr_addr_hi: le_hi=%b bus_out=%h want 1/00", a_le_hi, a_bus_out); end
    @(negedge clk); #1;
    checks++; if (a_le_hi !== 1'b0 || a_bus_out !== 8'h00) begin fails++; $display("FAIL rr_le_hi_fall: le_hi=%b bus_out=%h want 0/00", a_le_hi, a_bus_out); end
    tick;
    checks++; if (a_le_lo !== 1'b1 || a_le_hi !== 1'b0 || a_bus_out !== 8'h00) begin fails++; $display("FAIL rr_addr_lo: le_lo=%b le_hi=%b bus_out=%h want 1/0/00", a_le_lo, a_le_hi, a_bus_out); end
    tick;
    checks++; if (a_oeb !== 1'b0 || a_bus_oe !== 1'b0) begin fails++; $display("FAIL rr_read: OEb=%b bus_oe=%b want 0/0", a_oeb, a_bus_oe); end
    tick;
    checks++; if (a_ack !== 2'b01 || a_rdata !== 8'h04 || a_oeb !== 1'b1) begin fails++; $display("FAIL rr_ack: ack=%b rdata=%h OEb=%b want 01/04/1", a_ack, a_rdata, a_oeb); end
    a_req = 2'b00;
  endtask

  task automatic test_skip_hi;
    tick;
    checks++; if (a_ack !== 2'b00) begin fails++; $display("FAIL skip_ack_pulse: got %b want 00", a_ack); end
    a_req = 2'b01; a_addr0 = 16'h0001; a_bus_in = 8'hA5;
    tick;
    checks++; if (a_le_hi !== 1'b0 || a_le_lo !== 1'b1 || a_bus_out !== 8'h01) begin fails++; $display("FAIL skip_lo: le_hi=%b le_lo=%b bus_out=%h want 0/1/01", a_le_hi, a_le_lo, a_bus_out); end
    tick;
    checks++; if (a_oeb !== 1'b0) begin fails++; $display("FAIL skip_read: OEb=%b want 0", a_oeb); end
    tick;
    checks++; if (a_ack !== 2'b01 || a_rdata !== 8'hA5) begin fails++; $display("FAIL skip_ack: ack=%b rdata=%h want 01/a5", a_ack, a_rdata); end
    a_req = 2'b00;
    tick;
    a_req = 2'b01; a_addr0 = 16'h07D0; a_bus_in = 8'h6E;
    tick;
    checks++; if (a_le_hi !== 1'b1 || a_bus_out !== 8'h07) begin fails++; $display("FAIL newhi_hi: le_hi=%b bus_out=%h want 1/07", a_le_hi, a_bus_out); end
    tick;
    checks++; if (a_le_lo !== 1'b1 || a_bus_out !== 8'hD0) begin fails++; $display("FAIL newhi_lo: le_lo=%b bus_out=%h want 1/d0", a_le_lo, a_bus_out); end
    tick; tick;
    checks++; if (a_ack !== 2'b01 || a_rdata !== 8'h6E) begin fails++; $display("FAIL newhi_ack: ack=%b rdata=%h want 01/6e", a_ack, a_rdata); end
    a_req = 2'b00;
    tick;
  endtask

  task automatic test_write;
    a_req = 2'b01; a_we = 2'b01; a_addr0 = 16'h0102; a_wdata0 = 8'h32;
    tick;
    checks++; if (a_le_hi !== 1'b1 || a_bus_out !== 8'h01) begin fails++; $display("FAIL wr_hi: le_hi=%b bus_out=%h want 1/01", a_le_hi, a_bus_out); end
    tick;
    checks++; if (a_le_lo !== 1'b1 || a_bus_out !== 8'h02) begin fails++; $display("FAIL wr_lo: le_lo=%b bus_out=%h want 1/02", a_le_lo, a_bus_out); end
    tick;
    checks++; if (a_web !== 1'b0 || a_bus_out !== 8'h32 || a_bus_oe !== 1'b1 || a_oeb !== 1'b1) begin fails++; $display("FAIL wr_strobe: WEb=%b bus_out=%h bus_oe=%b OEb=%b want 0/32/1/1", a_web, a_bus_out, a_bus_oe, a_oeb); end
    tick;
    checks++; if (a_web !== 1'b1 || a_bus_out !== 8'h32 || a_bus_oe !== 1'b1 || a_ack !== 2'b00) begin fails++; $display("FAIL wr_hold: WEb=%b bus_out=%h bus_oe=%b ack=%b want 1/32/1/00", a_web, a_bus_out, a_bus_oe, a_ack); end
    tick;
    checks++; if (a_ack !== 2'b01) begin fails++; $display("FAIL wr_ack: ack=%b want 01", a_ack); end
    a_req = 2'b00; a_we = 2'b00;
    tick;
  endtask

  task automatic test_arbitration;
    int n;
    logic prev;
    n = 0; prev = 1'b0;
    rst = 1'b1;
    tick;
    a_req = 2'b11; a_we = 2'b00; a_addr0 = 16'h0102; a_addr1 = 16'h0180; a_bus_in = 8'h3C;
    rst = 1'b0;
    for (int c = 0; c < 40; c++) begin
      tick;
      if (a_ack !== 2'b00) begin
        checks++; if (a_ack === 2'b11) begin fails++; $display("FAIL arb_both_acked: ack=%b", a_ack); end
        checks++;
        if (n == 0) begin
          if (a_ack[0] !== 1'b1) begin fails++; $display("FAIL arb_first: ack=%b want 01", a_ack); end
        end else if (a_ack[1] === prev) begin
          fails++; $display("FAIL arb_alternate: ack=%b repeats port %0d", a_ack, prev);
        end
        checks++; if (a_rdata !== 8'h3C) begin fails++; $display("FAIL arb_rdata: got %h want 3c", a_rdata); end
        prev = a_ack[1];
        n++;
      end
    end
    a_req = 2'b00;
    checks++; if (n != 13) begin fails++; $display("FAIL arb_count: got %0d acks want 13", n); end
    tick;
  endtask

  task automatic test_wait_states;
    int low, lat;
    logic [7:0] exp_rd;
    logic done;
    low = 0; lat = 0; exp_rd = 8'h00; done = 1'b0;
    b_req = 2'b01; b_we = 2'b00; b_addr0 = 16'h4C87; b_bus_in = 8'h00;
    for (int c = 0; c < 20 && !done; c++) begin
      tick;
      lat++;
      if (b_ack !== 2'b00) begin
        done = 1'b1;
        checks++; if (b_ack !== 2'b01 || b_rdata !== exp_rd) begin fails++; $display("FAIL ws_ack: ack=%b rdata=%h want 01/%h", b_ack, b_rdata, exp_rd); end
      end else if (b_oeb === 1'b0) begin
        low++;
        b_bus_in = 8'h30 + 8'(low);
        exp_rd = b_bus_in;
      end
    end
    b_req = 2'b00;
    checks++; if (!done) begin fails++; $display("FAIL ws_timeout: no ack within 20 cycles"); end
    checks++; if (low != 3) begin fails++; $display("FAIL ws_oeb_len: got %0d cycles want 3", low); end
    checks++; if (lat != 6) begin fails++; $display("FAIL ws_latency: got %0d want 6", lat); end
    tick;
  endtask

  task automatic test_reset_mid_write;
    int lat;
    logic done;
    lat = 0; done = 1'b0;
    a_req = 2'b01; a_we = 2'b01; a_addr0 = 16'h0102; a_wdata0 = 8'h5E;
    tick;
    checks++; if (a_le_hi !== 1'b0 || a_le_lo !== 1'b1) begin fails++; $display("FAIL mw_skip: le_hi=%b le_lo=%b want 0/1", a_le_hi, a_le_lo); end
    tick;
    checks++; if (a_web !== 1'b0) begin fails++; $display("FAIL mw_web_low: WEb=%b want 0", a_web); end
    #2 rst = 1'b1;
    #1;
    checks++; if (a_web !== 1'b1 || a_bus_oe !== 1'b1 || a_ack !== 2'b00) begin fails++; $display("FAIL mw_async: WEb=%b bus_oe=%b ack=%b want 1/1/00", a_web, a_bus_oe, a_ack); end
    tick; tick;
    checks++; if (a_ack !== 2'b00) begin fails++; $display("FAIL mw_no_ack: ack=%b want 00", a_ack); end
    rst = 1'b0;
    tick;
    checks++; if (a_le_hi !== 1'b1 || a_bus_out !== 8'h01) begin fails++; $display("FAIL mw_rehi: le_hi=%b bus_out=%h want 1/01", a_le_hi, a_bus_out); end
    lat = 1;
    for (int c = 0; c < 10 && !done; c++) begin
      tick;
      lat++;
      if (a_ack !== 2'b00) done = 1'b1;
    end
    a_req = 2'b00; a_we = 2'b00;
    checks++; if (!done || lat != 5) begin fails++; $display("FAIL mw_reissue: done=%b latency=%0d want 1/5", done, lat); end
    tick;
  endtask

  initial begin
    checks = 0;
    fails  = 0;
    test_reset;
    test_reset_release_read;
    test_skip_hi;
    test_write;
    test_arbitration;
    test_wait_states;
    test_reset_mid_write;
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

endmodule
